mdio_reader: RTL
================

# mdio_reader

MDIO management-interface master that issues IEEE 802.3 Clause 22 read frames and returns the 16-bit register value. It generates MDC from the system clock and drives the MDIO tristate as three discrete signals (`mdio_i`/`mdio_o`/`mdio_t`), which are joined into a pad at the top level. It pairs with the existing MDIO write path on the same PHY management bus. Requests and responses each use a valid/ready handshake, so a host FSM or register block can poll PHY status and ID registers.

## Interface
- `CLK_DIV_HALF`, default 125: number of clk cycles per MDC half-period. MDC period is 2*CLK_DIV_HALF clk; at 125 MHz that is 500 kHz. Legal values are ≥ 2.
- `PREAMBLE_BITS`, default 32: number of preamble '1' bits sent before START.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: a read request is presented.
- `req_ready`  out  1: high only in IDLE.
- `req_phy_addr`  in  5: PHY address, captured at request handshake.
- `req_reg_addr`  in  5: register address, captured at request handshake.
- `rsp_valid`  out  1: response is available; held until `rsp_ready`.
- `rsp_ready`  in  1: response consumer is ready.
- `rsp_data`  out  16: register value read, MSB first.
- `rsp_error`  out  1: second turnaround bit was sampled as 1, meaning no PHY responded.
- `mdio_i`  in  1: MDIO pad input.
- `mdio_o`  out  1: MDIO drive value.
- `mdio_t`  out  1: 1 = released (high-Z), 0 = driving.
- `mdc`  out  1: management clock.

## Operation
- **MDC generation:** MDC is free-running from reset. A counter runs 0..CLK_DIV_HALF-1; at terminal count MDC toggles and the counter clears.
  - `fall` strobe = terminal count while mdc=1.
  - `rise` strobe = terminal count while mdc=0.
- **Edge rules:**
  - All MDIO drive changes (`mdio_o`, `mdio_t`) occur only on a `fall` strobe cycle.
  - `mdio_i` is sampled only on a `rise` strobe cycle, i.e. the value just before MDC goes high.
- **States:**
  - **IDLE:** `req_ready`=1. A handshake latches the addresses, loads a 14-bit shift register with {01, 10, phy[4:0], reg[4:0]}, and moves to WAIT_FALL.
  - **WAIT_FALL:** on the next `fall` → PREAMBLE; `mdio_t`=0, `mdio_o`=1.
  - **PREAMBLE:** drive 1 for PREAMBLE_BITS MDC periods. A bit counter advances on each `fall`. Then → HEADER.
  - **HEADER:** shift out 14 bits MSB first, one per `fall`. Then → TA.
  - **TA:** on entry `fall`, set `mdio_t`=1 (released for both TA bits). The `rise` of TA bit 2 samples `mdio_i`; if it is 1, set the error flag. On the following `fall` → DATA.
  - **DATA:** 16 `rise` samples shift into `rsp_data`, MSB first. After the 16th sample, the next `fall` → RESP.
  - **RESP:** `rsp_valid`=1; `mdio_t` stays 1. On `rsp_valid && rsp_ready` → IDLE, and `rsp_valid` drops the next cycle.
- **No-PHY case:** data bits are still captured from `mdio_i`, giving 0xFFFF with a pulled-up bus. `rsp_error` is reported alongside the data, and `rsp_error` is cleared at each new request.
- **Request timing:** `req_valid` is ignored outside IDLE. A request can be accepted the cycle after a response handshake, but not in the same cycle.

## Timing
- **Reset values:**
  - state IDLE, MDC counter 0
  - `mdc`=0, `mdio_t`=1, `mdio_o`=0
  - `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0
  - `req_ready`=1 (decoded from state)
- **Frame length:** PREAMBLE_BITS+2+2+5+5+2+16 MDC periods, which is 64 with the defaults.
- **Latency:** from request handshake to `rsp_valid` is between 64*2*CLK_DIV_HALF and (64+1)*2*CLK_DIV_HALF + 1 clk, depending on alignment to the next `fall`.
- **Reset mid-frame:** one cycle after reset asserts, `mdio_t`=1 and `mdc`=0. No response is produced and all state is discarded.
- **Back-pressure:** while `rsp_valid` is held, `rsp_data` and `rsp_error` stay stable. MDC keeps running, and no bus activity occurs.

## Structure
- **Package `mdio_pkg`** (shared with the writer) holds:
  - MDIO_START=2'b01, MDIO_OP_READ=2'b10, MDIO_OP_WRITE=2'b01
  - MDIO_TA_WRITE=2'b10
  - MDIO_PREAMBLE_DEFAULT=32
  - the `mdio_reader_state_t` enum
- **Sub-module `mdio_clk_gen`** (parameter CLK_DIV_HALF; outputs `mdc`, `rise`, `fall`), reusable by the writer.
- The frame is built with a shift register and bit counter, not one state per bit.

## Test plan
- **Basic read:** CLK_DIV_HALF=4; read phy=1, reg=0x02; the bench PHY drives 0 in TA then 0x0141 after each MDC rise → `rsp_data`=0x0141, `rsp_error`=0. The driven sequence is 32×'1' then 01 10 00001 00010. `mdio_t`=1 from TA bit 1 through RESP.
- **No PHY:** `mdio_i` tied 1, read reg 0x03 → `rsp_data`=0xFFFF, `rsp_error`=1.
- **Edge and latency check:** CLK_DIV_HALF=4 → `mdc` period is 8 clk. Every `mdio_o`/`mdio_t` change coincides with an MDC fall. Latency is within [512, 521] clk.
- **Back-pressure:** `rsp_ready`=0 for 1000 cycles → `rsp_valid`/`rsp_data` stable, `req_ready`=0, and a `req_valid` pulse is ignored. Then `rsp_ready`=1 → handshake completes, and `req_ready`=1 the next cycle.
- **Reset mid-frame:** assert reset during DATA bit 8 → next cycle `mdio_t`=1, `mdc`=0, `rsp_valid`=0, `req_ready`=1. A subsequent read of 0xA5C3 returns correctly.
- **Back-to-back:** `req_valid` and `rsp_ready` held at 1 → two complete frames, each starting with the full preamble. Responses come in order: 0x1234, then 0x5678.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 definitions for the management-bus reader and writer.
package mdio_pkg;

    localparam logic [1:0] MDIO_START    = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

    localparam int unsigned MDIO_PREAMBLE_DEFAULT = 32;
    localparam int unsigned MDIO_ADDR_W           = 5;
    localparam int unsigned MDIO_DATA_W           = 16;
    localparam int unsigned MDIO_HDR_BITS         = 14;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FALL = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_HEADER    = 3'd3,
        ST_TA        = 3'd4,
        ST_DATA      = 3'd5,
        ST_RESP      = 3'd6
    } mdio_reader_state_t;

    // ST, OP, PHYAD, REGAD as shifted out MSB first for a read frame.
    function automatic logic [MDIO_HDR_BITS-1:0] mdio_read_header(
        input logic [MDIO_ADDR_W-1:0] phy_addr,
        input logic [MDIO_ADDR_W-1:0] reg_addr
    );
        return {MDIO_START, MDIO_OP_READ, phy_addr, reg_addr};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// Free-running MDC divider with single-cycle rise/fall strobes aligned to the MDC toggle.
module mdio_clk_gen #(
    parameter int unsigned CLK_DIV_HALF = 125
) (
    input  logic clk,
    input  logic reset,
    output logic mdc,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (CLK_DIV_HALF > 2) ? $clog2(CLK_DIV_HALF) : 1;

    logic [CNT_W-1:0] cnt;
    logic             tc;

    assign tc   = (cnt == CNT_W'(CLK_DIV_HALF - 1));
    assign rise = tc & ~mdc;
    assign fall = tc & mdc;

    // Half-period counter; MDC toggles and the counter clears at terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mdio_reader.sv
// Clause 22 MDIO read master: preamble, header, turnaround, 16 data bits, then a held response.
module mdio_reader
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV_HALF  = 125,
    parameter int unsigned PREAMBLE_BITS = MDIO_PREAMBLE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [MDIO_ADDR_W-1:0] req_phy_addr,
    input  logic [MDIO_ADDR_W-1:0] req_reg_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MDIO_DATA_W-1:0] rsp_data,
    output logic                   rsp_error,
    input  logic                   mdio_i,
    output logic                   mdio_o,
    output logic                   mdio_t,
    output logic                   mdc
);

    localparam int unsigned BIT_CNT_MAX = (PREAMBLE_BITS > MDIO_DATA_W) ? PREAMBLE_BITS : MDIO_DATA_W;
    localparam int unsigned BIT_CNT_W   = $clog2(BIT_CNT_MAX + 1);

    mdio_reader_state_t       state;
    logic [MDIO_HDR_BITS-1:0] hdr_sr;
    logic [BIT_CNT_W-1:0]     bit_cnt;
    logic                     mdc_rise;
    logic                     mdc_fall;

    mdio_clk_gen #(
        .CLK_DIV_HALF(CLK_DIV_HALF)
    ) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .mdc   (mdc),
        .rise  (mdc_rise),
        .fall  (mdc_fall)
    );

    assign req_ready = (state == ST_IDLE);

    // Frame sequencer: drive changes only on fall strobes, samples only on rise strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hdr_sr    <= '0;
            bit_cnt   <= '0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        hdr_sr    <= mdio_read_header(req_phy_addr, req_reg_addr);
                        rsp_error <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= ST_WAIT_FALL;
                    end
                end

                ST_WAIT_FALL: begin
                    if (mdc_fall) begin
                        mdio_t  <= 1'b0;
                        mdio_o  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    if (mdc_fall) begin
                        if (bit_cnt == BIT_CNT_W'(PREAMBLE_BITS - 1)) begin
                            mdio_o  <= hdr_sr[MDIO_HDR_BITS-1];
                            hdr_sr  <= {hdr_sr[MDIO_HDR_BITS-2:0], 1'b0};
                            bit_cnt <= '0;
                            state   <= ST_HEADER;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_HEADER: begin
                    if (mdc_fall) begin
                        if (bit_cnt == BIT_CNT_W'(MDIO_HDR_BITS - 1)) begin
                            mdio_t  <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_TA;
                        end else begin
                            mdio_o  <= hdr_sr[MDIO_HDR_BITS-1];
                            hdr_sr  <= {hdr_sr[MDIO_HDR_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                ST_TA: begin
                    if (mdc_fall) begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= BIT_CNT_W'(1);
                        end else begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end else if (mdc_rise && (bit_cnt == BIT_CNT_W'(1))) begin
                        // A PHY pulls the second TA bit low; a high level means nobody answered.
                        rsp_error <= mdio_i;
                    end
                end

                ST_DATA: begin
                    if (mdc_rise) begin
                        rsp_data <= {rsp_data[MDIO_DATA_W-2:0], mdio_i};
                        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                    end else if (mdc_fall && (bit_cnt == BIT_CNT_W'(MDIO_DATA_W))) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
